// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Contents: FSM state encoding, access-owner encoding, wait-state limits.
package sram_arb_pkg;

    // Largest legal wait-state count and the counter width that holds it.
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

endpackage : sram_arb_pkg

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the CPU and DMA request lines.
// Build option: SRAM_ARB_RR_EN selects round-robin; otherwise CPU has fixed priority.
// Ports:
//   cpu_req, dma_req  request lines sampled by the arbiter in IDLE
//   last_owner        port granted most recently (only consulted in round-robin)
//   grant_c           at least one request present
//   owner_c           winning port
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dma_req,
    input  arb_owner_t last_owner,
    output logic       grant_c,
    output arb_owner_t owner_c
);

    // Winner select; on a tie round-robin favours the port not granted last.
    always_comb begin
        grant_c = cpu_req | dma_req;
        owner_c = OWN_CPU;
`ifdef SRAM_ARB_RR_EN
        if (cpu_req && dma_req) begin
            owner_c = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (dma_req) begin
            owner_c = OWN_DMA;
        end
`else
        if (!cpu_req && dma_req) begin
            owner_c = OWN_DMA;
        end
`endif
    end

`ifndef SRAM_ARB_RR_EN
    // Fixed priority has no use for the history input.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule : sram_arb_pick

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU port and the DMA/loader port.
// Generates the active-low SRAM strobes with WAIT_CYCLES access cycles, returns a
// one-cycle ready pulse to the owning port per completed access. All outputs are registered.
// Build option: SRAM_ARB_RR_EN enables round-robin arbitration (default: CPU fixed priority).
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   cpu_* / dma_*              req/we/addr/wdata in, rdata/ready out per requester
//   sram_addr, sram_dout       registered SRAM address and write data
//   sram_dout_oe               top-level tri-state enable for sram_dout
//   sram_din                   SRAM data bus input
//   Mem_CE, Mem_OE, Mem_WE     active-low SRAM strobes
//   arb_state                  current FSM state for debug
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_oe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [1:0]        arb_state
);

    if (WAIT_CYCLES == 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYCLES=%0d outside 1..%0d", WAIT_CYCLES, MAX_WAIT);
    end

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    arb_owner_t        owner_q, owner_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_dout_q, sram_dout_d;

    logic              mem_ce_n_q, mem_ce_n_d;
    logic              mem_oe_n_q, mem_oe_n_d;
    logic              mem_we_n_q, mem_we_n_d;
    logic              dout_oe_q, dout_oe_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dma_ready_q, dma_ready_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic              grant_c;
    arb_owner_t        pick_owner_c;
    arb_owner_t        pick_last;

    sram_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_owner (pick_last),
        .grant_c    (grant_c),
        .owner_c    (pick_owner_c)
    );

`ifdef SRAM_ARB_RR_EN
    // History of the last grant; reset value gives the CPU the first turn.
    arb_owner_t last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == ARB_IDLE && grant_c) begin
            last_owner_d = pick_owner_c;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_owner_q <= OWN_DMA;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign pick_last = last_owner_q;
`else
    assign pick_last = OWN_DMA;
`endif

    // State register and latched access context.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_CPU;
            op_we_q     <= 1'b0;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            op_we_q     <= op_we_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
        end
    end

    // Next state; the winner's operation is captured once at grant and never re-sampled.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        op_we_d     = op_we_q;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_c) begin
                    state_d = ARB_ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    owner_d = pick_owner_c;
                    if (pick_owner_c == OWN_DMA) begin
                        op_we_d     = dma_we;
                        sram_addr_d = dma_addr;
                        sram_dout_d = dma_wdata;
                    end else begin
                        op_we_d     = cpu_we;
                        sram_addr_d = cpu_addr;
                        sram_dout_d = cpu_wdata;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Output next values decoded from the next state so strobes line up with state_q.
    always_comb begin
        mem_ce_n_d  = 1'b1;
        mem_oe_n_d  = 1'b1;
        mem_we_n_d  = 1'b1;
        dout_oe_d   = 1'b0;
        cpu_ready_d = 1'b0;
        dma_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (state_d == ARB_ACCESS) begin
            mem_ce_n_d = 1'b0;
            mem_oe_n_d = op_we_d;
            mem_we_n_d = ~op_we_d;
            dout_oe_d  = op_we_d;
        end
        if (state_d == ARB_DONE) begin
            // Write data stays driven one cycle past the WE rising edge for hold time.
            dout_oe_d = op_we_d;
            if (owner_d == OWN_DMA) begin
                dma_ready_d = 1'b1;
                if (!op_we_d) begin
                    dma_rdata_d = sram_din;
                end
            end else begin
                cpu_ready_d = 1'b1;
                if (!op_we_d) begin
                    cpu_rdata_d = sram_din;
                end
            end
        end
    end

    // Output registers; reset releases the strobes immediately, aborting any access.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_ce_n_q  <= 1'b1;
            mem_oe_n_q  <= 1'b1;
            mem_we_n_q  <= 1'b1;
            dout_oe_q   <= 1'b0;
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            mem_ce_n_q  <= mem_ce_n_d;
            mem_oe_n_q  <= mem_oe_n_d;
            mem_we_n_q  <= mem_we_n_d;
            dout_oe_q   <= dout_oe_d;
            cpu_ready_q <= cpu_ready_d;
            dma_ready_q <= dma_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign Mem_CE       = mem_ce_n_q;
    assign Mem_OE       = mem_oe_n_q;
    assign Mem_WE       = mem_we_n_q;
    assign sram_dout_oe = dout_oe_q;
    assign sram_addr    = sram_addr_q;
    assign sram_dout    = sram_dout_q;
    assign cpu_ready    = cpu_ready_q;
    assign dma_ready    = dma_ready_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dma_rdata    = dma_rdata_q;
    assign arb_state    = state_q;

endmodule : sram_arbiter
